// File: rtl/mem_responder.sv
// Single-port word memory answering reads after a fixed pipeline latency.
// Writes complete on the accepting edge; reads return {data, addr} LATENCY cycles later.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] resp_addr,
    output logic [3:0]  outstanding
);

    logic [15:0]       mem_q [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] word_idx;
    logic              rd_acc;
    logic              wr_acc;

    logic              vld_q   [LATENCY];
    logic              vld_d   [LATENCY];
    logic [15:0]       data_q  [LATENCY];
    logic [15:0]       data_d  [LATENCY];
    logic [15:0]       raddr_q [LATENCY];
    logic [15:0]       raddr_d [LATENCY];
    logic [3:0]        outst_q;
    logic [3:0]        outst_d;

    assign word_idx = addr[ADDR_W:1];

    always_comb begin
        rd_acc = enable & ~wr;
        wr_acc = enable & wr;
    end

    // Invalid stages carry zeros so the last stage can drive the outputs directly.
    always_comb begin
        vld_d[0]   = rd_acc;
        data_d[0]  = rd_acc ? mem_q[word_idx] : 16'h0000;
        raddr_d[0] = rd_acc ? {addr[15:1], 1'b0} : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            data_d[i]  = data_q[i-1];
            raddr_d[i] = raddr_q[i-1];
        end
        outst_d = outst_q + {3'b000, rd_acc} - {3'b000, vld_q[LATENCY-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                data_q[i]  <= 16'h0000;
                raddr_q[i] <= 16'h0000;
            end
            outst_q <= 4'd0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= vld_d[i];
                data_q[i]  <= data_d[i];
                raddr_q[i] <= raddr_d[i];
            end
            outst_q <= outst_d;
        end
    end

    // Array contents survive reset; reset only blocks writes while asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wr_acc) begin
            mem_q[word_idx] <= data_in;
        end
    end

    assign data_valid  = vld_q[LATENCY-1];
    assign data_out    = data_q[LATENCY-1];
    assign resp_addr   = raddr_q[LATENCY-1];
    assign outstanding = outst_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to read response; legal range 1..8.
REQ-002 Parameter ADDR_W, default 15, word-address width; array holds 2^ADDR_W 16-bit words.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port enable  input  1  request valid this cycle; one request accepted per cycle, never back-pressured.
REQ-006 Port wr  input  1  1 = write request, 0 = read request; ignored when enable=0.
REQ-007 Port addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] ignored; bits above ADDR_W ignored (wrap).
REQ-008 Port data_in  input  16  write data; sampled with the write request.
REQ-009 Port data_out  output  16  read response data; valid only while data_valid=1.
REQ-010 Port data_valid  output  1  read response strobe, one cycle per accepted read.
REQ-011 Port resp_addr  output  16  addr of the read request being answered, with bit 0 forced to 0.
REQ-012 Port outstanding  output  4  count of accepted reads not yet answered.

Function
REQ-013 Request accepted on the rising edge where enable=1; no ready signal; requests never dropped.
REQ-014 Write: array[word index] <= data_in on the accepting edge; no response; data_valid unaffected.
REQ-015 Read: array word sampled on the accepting edge, after any earlier-cycle writes; result enters a LATENCY-stage pipeline of {valid, data, addr}.
REQ-016 Read accepted at edge N -> data_valid=1, data_out and resp_addr set during cycle after edge N+LATENCY-1 (LATENCY=4: three idle cycles, response in fourth).
REQ-017 Back-to-back reads on consecutive edges -> responses on consecutive cycles, same order, no gaps.
REQ-018 Write then read same word on the next edge -> read returns the new data.
REQ-019 Read accepted before a write to the same word returns the old data even if the write lands before the response.
REQ-020 data_valid=0 -> data_out=16'h0000 and resp_addr=16'h0000.
REQ-021 outstanding +1 on read acceptance, -1 on response-retire edge, unchanged when both occur on the same edge; never exceeds LATENCY.
REQ-022 Pipeline shifts every cycle; no stall input; writes interleaved with reads do not delay responses.
REQ-023 enable=0 cycles insert bubbles (valid=0 stages) and produce no response.

Reset
REQ-024 rst_n=0 asynchronously clears all pipeline valid bits, data_out, resp_addr, data_valid and outstanding to 0.
REQ-025 Reset mid-operation discards all in-flight reads; no response for any read accepted before reset.
REQ-026 Array contents are not cleared by reset; words written before reset remain readable after.
REQ-027 Requests with enable=1 while rst_n=0 are ignored; no write occurs.
REQ-028 First acceptance is on the first rising edge with rst_n=1.

Verification
REQ-029 Write 16'hBEEF to addr 16'h0010, read 16'h0011 next edge -> LATENCY=4: data_valid one cycle, data_out=16'hBEEF, resp_addr=16'h0010, 4th cycle after the read edge.
REQ-030 Reads of 16'h0000, 0002, 0004, 0006 on four consecutive edges after preloading 1,2,3,4 -> responses 1,2,3,4 on four consecutive cycles; outstanding peaks at 4 and returns to 0.
REQ-031 Read 16'h0020 (holding 16'h1111), write 16'h2222 to 16'h0020 next edge -> response 16'h1111; a later read returns 16'h2222.
REQ-032 Three reads in flight, pulse rst_n low for one cycle -> data_valid stays 0 thereafter, outstanding=0; earlier-written word still reads back correctly after reset.
REQ-033 ADDR_W=4: write 16'h00AA to 16'h0002, read 16'h0022 -> data_out=16'h00AA (address wrap).
REQ-034 Random mix of enable/wr over 1000 cycles against a reference memory model -> every response matches in data, address and order; outstanding always equals model count.
